wb_scoreboard: RTL

//  Write-back stage plus register scoreboard. Latches MEM-stage results (MEM/WB pipe reg), selects

---
 rtl/wb_scoreboard.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: write-back stage with a per-register in-flight scoreboard.
//
// Holds the MEM/WB pipeline register, builds the register-file write port
// (writeData/writeReg/RegWrite) and counts issued-but-unretired destination
// registers so decode can detect RAW hazards on its two read selects.
//
// Ports:
//   clk, rst          clock (posedge), asynchronous active-low reset
//   issue_*           decode issues an instruction writing issue_reg
//   rd1*/rd2*         decode read selects and their use flags
//   mem_*             MEM-stage result fields, loaded into MEM/WB
//   stall, flush      hold / invalidate the MEM/WB register
//   writeData/Reg,
//   RegWrite          register-file write port
//   hazard            a used read select has an in-flight writer
//   issue_full        issue_reg counter saturated; decode must not issue
//   halted            sticky, a HALT has retired
//   retired           retired-instruction counter (wraps)
//   err               sticky scoreboard underflow/overflow
//
// Build option: define WB_FWD_EN to add fwd_valid/fwd_reg/fwd_data and let
// hazard ignore a select whose only in-flight writer is writing this cycle.
module wb_scoreboard #(
  parameter int unsigned CNT_W = 2,
  parameter int unsigned RET_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [2:0]       issue_reg,
  input  logic [2:0]       rd1sel,
  input  logic [2:0]       rd2sel,
  input  logic             rd1used,
  input  logic             rd2used,
  input  logic             mem_valid,
  input  logic             mem_RegWrite,
  input  logic [2:0]       mem_writeReg,
  input  logic             mem_MemToReg,
  input  logic             mem_Link,
  input  logic             mem_halt,
  input  logic [15:0]      mem_aluResult,
  input  logic [15:0]      mem_readData,
  input  logic [15:0]      mem_pc,
  input  logic             stall,
  input  logic             flush,
  output logic [15:0]      writeData,
  output logic [2:0]       writeReg,
  output logic             RegWrite,
  output logic             hazard,
  output logic             issue_full,
  output logic             halted,
  output logic [RET_W-1:0] retired,
  output logic             err
`ifdef WB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [2:0]       fwd_reg,
  output logic [15:0]      fwd_data
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             wb_valid_q, wb_regwrite_q, wb_memtoreg_q, wb_link_q, wb_halt_q;
  logic [2:0]       wb_reg_q;
  logic [15:0]      wb_alu_q, wb_rdata_q, wb_pc_q;
  logic             halted_q, err_q, err_set, retire;
  logic [RET_W-1:0] retired_q;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       inc_vec, dec_vec;
  logic             rd1_fwd, rd2_fwd;

  assign writeData = wb_link_q ? wb_pc_q : (wb_memtoreg_q ? wb_rdata_q : wb_alu_q);
  assign writeReg  = wb_reg_q;
  assign RegWrite  = wb_valid_q & wb_regwrite_q & ~halted_q & ~stall;
  assign retire    = wb_valid_q & ~stall & ~halted_q;

  assign inc_vec = issue_valid ? (8'd1 << issue_reg) : 8'd0;
  assign dec_vec = RegWrite ? (8'd1 << writeReg) : 8'd0;

  // Simultaneous issue and retire of the same register cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    err_set = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CNT_MAX) err_set = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) err_set = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

`ifdef WB_FWD_EN
  // The sole in-flight writer is on the RF port now, so the value is forwarded.
  assign rd1_fwd   = RegWrite && (rd1sel == writeReg) && (cnt_q[rd1sel] == CNT_ONE);
  assign rd2_fwd   = RegWrite && (rd2sel == writeReg) && (cnt_q[rd2sel] == CNT_ONE);
  assign fwd_valid = RegWrite;
  assign fwd_reg   = writeReg;
  assign fwd_data  = writeData;
`else
  assign rd1_fwd = 1'b0;
  assign rd2_fwd = 1'b0;
`endif

  assign hazard = (rd1used && (cnt_q[rd1sel] != '0) && !rd1_fwd) ||
                  (rd2used && (cnt_q[rd2sel] != '0) && !rd2_fwd);
  assign issue_full = (cnt_q[issue_reg] == CNT_MAX);
  assign halted     = halted_q;
  assign retired    = retired_q;
  assign err        = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_link_q     <= 1'b0;
      wb_halt_q     <= 1'b0;
      wb_reg_q      <= '0;
      wb_alu_q      <= '0;
      wb_rdata_q    <= '0;
      wb_pc_q       <= '0;
      cnt_q         <= '{default: '0};
      halted_q      <= 1'b0;
      retired_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      // Flush only drops the valid bit; the data fields keep their last value.
      if (flush) begin
        wb_valid_q <= 1'b0;
      end else if (!stall) begin
        wb_valid_q    <= mem_valid;
        wb_regwrite_q <= mem_RegWrite;
        wb_memtoreg_q <= mem_MemToReg;
        wb_link_q     <= mem_Link;
        wb_halt_q     <= mem_halt;
        wb_reg_q      <= mem_writeReg;
        wb_alu_q      <= mem_aluResult;
        wb_rdata_q    <= mem_readData;
        wb_pc_q       <= mem_pc;
      end
      cnt_q <= cnt_d;
      err_q <= err_q | err_set;
      if (retire) begin
        retired_q <= retired_q + 1'b1;
        if (wb_halt_q) halted_q <= 1'b1;
      end
    end
  end

endmodule
